// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, ALU
// operations, opcode/funct values and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_IEXE   = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op >= OP_ADDI) && (op <= OP_XORI);
  endfunction

  function automatic logic is_logic_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/mips_mc_control_alu_decode.sv
// ALU operation and immediate-extender mode for the current state, decoded
// from the registered opcode/funct. Also flags whether an R-type funct exists.
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       zero_extend,
  output logic       funct_valid
);

  logic [3:0] rt_op;

  always_comb begin
    rt_op       = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      F_ADD, F_ADDU: rt_op = ALU_ADD;
      F_SUB, F_SUBU: rt_op = ALU_SUB;
      F_AND:         rt_op = ALU_AND;
      F_OR:          rt_op = ALU_OR;
      F_XOR:         rt_op = ALU_XOR;
      F_NOR:         rt_op = ALU_NOR;
      F_SLT:         rt_op = ALU_SLT;
      F_SLTU:        rt_op = ALU_SLTU;
      default:       funct_valid = 1'b0;
    endcase

    alu_ctrl    = ALU_ADD;
    zero_extend = 1'b0;
    case (state)
      S_RTEXE:  alu_ctrl = rt_op;
      S_IEXE: begin
        zero_extend = is_logic_imm(opcode);
        case (opcode)
          OP_SLTI:  alu_ctrl = ALU_SLT;
          OP_SLTIU: alu_ctrl = ALU_SLTU;
          OP_ANDI:  alu_ctrl = ALU_AND;
          OP_ORI:   alu_ctrl = ALU_OR;
          OP_XORI:  alu_ctrl = ALU_XOR;
          default:  alu_ctrl = ALU_ADD;
        endcase
      end
      // Extender mode must stay stable while the result is written back.
      S_IWB:    zero_extend = is_logic_imm(opcode);
      S_BRANCH: alu_ctrl = ALU_SUB;
      default:  ;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and drives every datapath select and write strobe from the current state.
module mips_mc_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUCtrl,
  output logic [1:0] PCSource,
  output logic       ZeroExtend,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t state_q, state_d;
  logic   funct_valid;

  mips_alu_decode u_alu_decode (
    .state       (state_q),
    .opcode      (opcode),
    .funct       (funct),
    .alu_ctrl    (ALUCtrl),
    .zero_extend (ZeroExtend),
    .funct_valid (funct_valid)
  );

  // Memory handshake: MemRead/MemWrite request an access and stay asserted,
  // unchanged, until a cycle with mem_ready=1; that cycle completes the access
  // and the FSM advances. mem_ready is a don't-care outside FETCH/MEMRD/MEMWR.
  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    PCSource   = PCSRC_ALU;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_MEMADR;
        end else if (opcode == OP_RTYPE && funct_valid) begin
          state_d = S_RTEXE;
        end else if (is_imm_alu(opcode)) begin
          state_d = S_IEXE;
        end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
          state_d = S_BRANCH;
        end else if (opcode == OP_J) begin
          state_d = S_JUMP;
        end else begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_RTEXE: begin
        ALUSrcA = 1'b1;
        state_d = S_RTWB;
      end
      S_RTWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_IEXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        PCSource   = PCSRC_ALUOUT;
        PCWrite    = (opcode == OP_BNE) ? !alu_zero : alu_zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCSource   = PCSRC_JUMP;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset must silence every write immediately, even mid-access.
    if (rst) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: walks each instruction class cycle by
// cycle and compares the full output bundle against hand-derived vectors.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       alu_zero, mem_ready;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
  logic       IorD, RegDst, MemtoReg, ALUSrcA, ZeroExtend;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUCtrl;
  logic       instr_done, illegal_op;

  int errors = 0;
  int checks = 0;

  mips_mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .IorD(IorD),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl), .PCSource(PCSource),
    .ZeroExtend(ZeroExtend), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Bit order: pcw irw mr mw rw | iord rd m2r sa | sb[2] alu[4] ps[2] | ze done ill
  localparam logic [19:0] STROBE_MASK = 20'b11111_0000_00000000_011;

  function automatic logic [19:0] v(
    input logic pcw, irw, mr, mw, rw, iord, rd, m2r, sa,
    input logic [1:0] sb, input logic [3:0] alu, input logic [1:0] ps,
    input logic ze, dn, il);
    return {pcw, irw, mr, mw, rw, iord, rd, m2r, sa, sb, alu, ps, ze, dn, il};
  endfunction

  function automatic logic [19:0] outs();
    return {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, IorD, RegDst,
            MemtoReg, ALUSrcA, ALUSrcB, ALUCtrl, PCSource, ZeroExtend,
            instr_done, illegal_op};
  endfunction

  // Check the current cycle's outputs, then move to the next cycle.
  task automatic cyc(input string tag, input logic [19:0] exp, input logic [19:0] mask);
    logic [19:0] got;
    #1;
    got = outs() & mask;
    checks++;
    assert (got === (exp & mask)) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, got, exp & mask);
    end
    @(negedge clk);
  endtask

  localparam logic [19:0] ALL = 20'hFFFFF;

  logic [19:0] fetch_v, decode_v;

  initial begin
    fetch_v  = v(1,1,1,0,0, 0,0,0,0, 2'd1, 4'd0, 2'd0, 0,0,0);
    decode_v = v(0,0,0,0,0, 0,0,0,0, 2'd3, 4'd0, 2'd0, 0,0,0);
    rst = 1'b1; opcode = 6'h00; funct = 6'h20; alu_zero = 1'b0; mem_ready = 1'b1;

    // Reset: strobes low while rst is held
    cyc("reset_c0", 20'h0, STROBE_MASK);
    cyc("reset_c1", 20'h0, STROBE_MASK);
    rst = 1'b0;

    // ori: 4 cycles, zero-extended OR immediate
    opcode = 6'h0D;
    cyc("ori_fetch",  fetch_v, ALL);
    cyc("ori_decode", decode_v, ALL);
    cyc("ori_iexe",   v(0,0,0,0,0, 0,0,0,1, 2'd2, 4'd3, 2'd0, 1,0,0), ALL);
    cyc("ori_iwb",    v(0,0,0,0,1, 0,0,0,0, 2'd0, 4'd0, 2'd0, 1,1,0), ALL);

    // addi: sign-extended ADD immediate
    opcode = 6'h08;
    cyc("addi_fetch",  fetch_v, ALL);
    cyc("addi_decode", decode_v, ALL);
    cyc("addi_iexe",   v(0,0,0,0,0, 0,0,0,1, 2'd2, 4'd0, 2'd0, 0,0,0), ALL);
    cyc("addi_iwb",    v(0,0,0,0,1, 0,0,0,0, 2'd0, 4'd0, 2'd0, 0,1,0), ALL);

    // lw with a two-cycle MEMRD stall: 7 cycles total
    opcode = 6'h23;
    cyc("lw_fetch",  fetch_v, ALL);
    cyc("lw_decode", decode_v, ALL);
    cyc("lw_memadr", v(0,0,0,0,0, 0,0,0,1, 2'd2, 4'd0, 2'd0, 0,0,0), ALL);
    mem_ready = 1'b0;
    cyc("lw_memrd_stall0", v(0,0,1,0,0, 1,0,0,0, 2'd0, 4'd0, 2'd0, 0,0,0), ALL);
    cyc("lw_memrd_stall1", v(0,0,1,0,0, 1,0,0,0, 2'd0, 4'd0, 2'd0, 0,0,0), ALL);
    mem_ready = 1'b1;
    cyc("lw_memrd_ready",  v(0,0,1,0,0, 1,0,0,0, 2'd0, 4'd0, 2'd0, 0,0,0), ALL);
    cyc("lw_memwb",        v(0,0,0,0,1, 0,0,1,0, 2'd0, 4'd0, 2'd0, 0,1,0), ALL);

    // beq taken
    opcode = 6'h04; alu_zero = 1'b1;
    cyc("beq_fetch",  fetch_v, ALL);
    cyc("beq_decode", decode_v, ALL);
    cyc("beq_branch", v(1,0,0,0,0, 0,0,0,1, 2'd0, 4'd1, 2'd1, 0,1,0), ALL);

    // bne with alu_zero=1: no PC write
    opcode = 6'h05;
    cyc("bne_fetch",  fetch_v, ALL);
    cyc("bne_decode", decode_v, ALL);
    cyc("bne_branch", v(0,0,0,0,0, 0,0,0,1, 2'd0, 4'd1, 2'd1, 0,1,0), ALL);

    // bne with alu_zero=0: taken
    alu_zero = 1'b0;
    cyc("bne_t_fetch",  fetch_v, ALL);
    cyc("bne_t_decode", decode_v, ALL);
    cyc("bne_t_branch", v(1,0,0,0,0, 0,0,0,1, 2'd0, 4'd1, 2'd1, 0,1,0), ALL);

    // R-type SUB
    opcode = 6'h00; funct = 6'h22;
    cyc("sub_fetch",  fetch_v, ALL);
    cyc("sub_decode", decode_v, ALL);
    cyc("sub_rtexe",  v(0,0,0,0,0, 0,0,0,1, 2'd0, 4'd1, 2'd0, 0,0,0), ALL);
    cyc("sub_rtwb",   v(0,0,0,0,1, 0,1,0,0, 2'd0, 4'd0, 2'd0, 0,1,0), ALL);

    // R-type with unsupported funct 0x00: illegal, back to FETCH
    funct = 6'h00;
    cyc("badfn_fetch",  fetch_v, ALL);
    cyc("badfn_decode", v(0,0,0,0,0, 0,0,0,0, 2'd3, 4'd0, 2'd0, 0,1,1), ALL);

    // Unsupported opcode 0x3F, preceded by a one-cycle FETCH stall
    opcode = 6'h3F; mem_ready = 1'b0;
    cyc("badop_fetch_stall", v(0,0,1,0,0, 0,0,0,0, 2'd1, 4'd0, 2'd0, 0,0,0), ALL);
    mem_ready = 1'b1;
    cyc("badop_fetch",  fetch_v, ALL);
    cyc("badop_decode", v(0,0,0,0,0, 0,0,0,0, 2'd3, 4'd0, 2'd0, 0,1,1), ALL);

    // sw stalled in MEMWR, then reset aborts it
    opcode = 6'h2B;
    cyc("sw_fetch",  fetch_v, ALL);
    cyc("sw_decode", decode_v, ALL);
    cyc("sw_memadr", v(0,0,0,0,0, 0,0,0,1, 2'd2, 4'd0, 2'd0, 0,0,0), ALL);
    mem_ready = 1'b0;
    cyc("sw_memwr_stall", v(0,0,0,1,0, 1,0,0,0, 2'd0, 4'd0, 2'd0, 0,0,0), ALL);
    rst = 1'b1;
    cyc("sw_memwr_reset", 20'h0, STROBE_MASK);
    rst = 1'b0; mem_ready = 1'b1;

    // j: first cycle after reset is FETCH
    opcode = 6'h02;
    cyc("j_fetch",  fetch_v, ALL);
    cyc("j_decode", decode_v, ALL);
    cyc("j_jump",   v(1,0,0,0,0, 0,0,0,0, 2'd0, 4'd0, 2'd2, 0,1,0), ALL);
    cyc("j_next_fetch", fetch_v, ALL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle MIPS control unit: sequences the shared datapath (PC, IR, register file, ALU, immediate extender, memory port) through fetch/decode/execute/memory/write-back states. It decodes the registered instruction's opcode/funct, drives every datapath select and write strobe, and configures the immediate extender's ZeroExtend input per instruction. It stalls on a single memory-ready handshake and sits between the instruction register and the datapath muxes.

## Interface
- No parameters; the state and ALU-op encodings live in the shared package.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], registered
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, IRWrite, MemRead, MemWrite, RegWrite  out  1 each  strobes
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = MDR
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  0 = B, 1 = const 4, 2 = ext imm, 3 = ext imm<<2
- ALUCtrl  out  4  ALU operation
- PCSource  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- ZeroExtend  out  1  immediate extender mode
- instr_done  out  1  one-cycle pulse on the final cycle of an instruction
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode/funct is unsupported

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, IEXE, IWB, BRANCH, JUMP.
- FETCH
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUCtrl=ADD, PCSource=0.
  - IRWrite and PCWrite are asserted only when mem_ready=1, which advances to DECODE. Otherwise the state holds.
- DECODE
  - ALUSrcA=0, ALUSrcB=3, ADD (branch target), ZeroExtend forced 0.
  - Dispatch:
    - lw 0x23 / sw 0x2B → MEMADR
    - R-type 0x00 → RTEXE
    - addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B, andi 0x0C, ori 0x0D, xori 0x0E → IEXE
    - beq 0x04 / bne 0x05 → BRANCH
    - j 0x02 → JUMP
    - other → FETCH with illegal_op=1 and instr_done=1
- MEMADR: ALUSrcA=1, ALUSrcB=2, ADD, ZeroExtend=0. Goes to MEMRD (lw) or MEMWR (sw).
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, instr_done.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready, then FETCH with instr_done.
- RTEXE: ALUSrcA=1, ALUSrcB=0, ALUCtrl from funct.
  - Supported funct: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU.
  - An unsupported funct pulses illegal_op in DECODE and returns to FETCH.
- RTWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done.
- IEXE: ALUSrcA=1, ALUSrcB=2.
  - ZeroExtend=1 for andi/ori/xori; 0 for addi/addiu/slti/sltiu.
  - ALUCtrl: ADD, ADD, SLT, SLTU, AND, OR, XOR respectively.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done. ZeroExtend keeps its IEXE value.
- BRANCH: ALUSrcA=1, ALUSrcB=0, SUB, PCSource=1, ZeroExtend=0.
  - PCWrite = alu_zero for beq, !alu_zero for bne.
  - Goes to FETCH with instr_done.
- JUMP: PCSource=2, PCWrite=1, instr_done, then FETCH.
- Every unlisted output is 0 in every state.

## Timing
- State register updates on the clk rising edge. Outputs are combinational from the state and the registered opcode/funct (Moore plus decode); there are no output registers.
- Reset:
  - While rst=1, all strobes (PCWrite, IRWrite, MemRead, MemWrite, RegWrite, instr_done, illegal_op) are 0.
  - The state becomes FETCH at the edge. The first cycle after rst falls is FETCH.
  - rst mid-instruction (including a pending MEMRD/MEMWR) abandons it without issuing any further write.
- Cycle counts, with mem_ready=1 throughout:
  - lw 5; sw 4; R-type 4; I-ALU 4
  - beq/bne 3; j 3; illegal 2
- Each cycle with mem_ready=0 in FETCH/MEMRD/MEMWR adds exactly one cycle. Strobes stay asserted and stable across the stall.
- mem_ready is ignored in all other states.

## Structure
- Package mips_ctrl_pkg holds:
  - state enum (4-bit)
  - ALU op constants: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7
  - opcode/funct constants
  - ALUSrcB/PCSource select constants
- One sub-module, mips_alu_decode: combinational opcode/funct/state → ALUCtrl, ZeroExtend, funct_valid. The FSM stays in mips_mc_control.

## Test plan
- ori (opcode 0x0D), mem_ready=1 → FETCH, DECODE, IEXE, IWB.
  - IEXE: ZeroExtend=1, ALUCtrl=OR, ALUSrcB=2.
  - IWB: RegWrite=1, RegDst=0, instr_done=1.
- addi 0x08 → ZeroExtend=0 in IEXE. lw 0x23 with mem_ready low for 2 cycles in MEMRD → 7 total cycles; MemRead/IorD held high across the stall.
- beq with alu_zero=1 → PCWrite=1, PCSource=1 in cycle 3. bne with alu_zero=1 → PCWrite=0. Both pulse instr_done.
- R-type funct 0x22 → ALUCtrl=SUB in RTEXE. funct 0x00 → illegal_op pulse in DECODE, then FETCH, with no RegWrite.
- Assert rst during MEMWR while mem_ready=0 → MemWrite=0 in the reset cycle; FETCH on the following cycle.
- j 0x02 → PCSource=2, PCWrite=1 in cycle 3, then FETCH.
